push_button_event_fifo: RTL and testbench
=========================================

# push_button_event_fifo

Downstream consumer of one or more debounced push-button stages. Arbitrates their `press_activated` requests, returns a one-cycle `press_accepted` acknowledge to the winner, and records each accepted press in a small FIFO. Each FIFO entry holds the button index and a free-running timestamp. Software or a CPU-side register block pops events at its own pace, so no press is lost while the FIFO has room.

## Interface
Parameters:
- `NUM_BUTTONS`, 4: number of button inputs; range 1..16.
- `FIFO_DEPTH`, 8: number of entries; must be a power of 2, at least 2.
- `TIME_WIDTH`, 16: width of the timestamp counter and of stored timestamps.
- Derived: `IDX_W = max(1, clog2(NUM_BUTTONS))`; `PTR_W = clog2(FIFO_DEPTH)`.

Ports:
- `clock`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `press_activated`, in, NUM_BUTTONS: per-button press request, level, held until acknowledged.
- `press_accepted`, out, NUM_BUTTONS: per-button acknowledge; registered, one-hot or zero, one-cycle pulse.
- `event_valid`, out, 1: FIFO not empty.
- `event_button`, out, IDX_W: button index of the head entry; 0 when empty.
- `event_time`, out, TIME_WIDTH: timestamp of the head entry; 0 when empty.
- `event_read`, in, 1: pop strobe; ignored when `event_valid` = 0.
- `event_count`, out, PTR_W+1: number of stored entries, 0..FIFO_DEPTH.
- `fifo_full`, out, 1: `event_count == FIFO_DEPTH`.

## Operation
- Reset values:
  - `press_accepted` = 0.
  - Read and write pointers = 0.
  - `event_count` = 0, `event_valid` = 0, `fifo_full` = 0.
  - `event_button` = 0, `event_time` = 0.
  - Timestamp counter = 0.
  - Stored entries are don't-care.
- Timestamp: a TIME_WIDTH counter increments every cycle out of reset and wraps from all-ones to 0.
- A button is eligible when all three hold:
  - its `press_activated` bit = 1;
  - its `press_accepted` bit is currently 0, which blocks re-acceptance while the upstream stage is still clearing its request;
  - `fifo_full` = 0, as registered at the start of the cycle.
- Grant rule:
  - At most one grant per cycle.
  - Priority is fixed, lowest index wins.
  - There is no round-robin; ungranted requests stay pending and win on later cycles.
- On a granted edge:
  - The granted `press_accepted` bit goes to 1 for exactly one cycle.
  - The entry {index, current timestamp value} is written at the write pointer, and the write pointer increments modulo FIFO_DEPTH.
- Pop: when `event_read` = 1 and `event_valid` = 1, the read pointer increments modulo FIFO_DEPTH.
- Count update:
  - Push only: +1. Pop only: −1.
  - Push and pop on the same edge: unchanged. Both pointers still advance.
- Full behaviour (backpressure):
  - While full, no grants are made. Requests stay pending upstream, so nothing is dropped.
  - A pop on a full FIFO does not allow a push on the same edge. Grants resume on the next cycle.
- Empty behaviour: a pop with `event_valid` = 0 has no effect. Pointers and count stay unchanged.
- Head outputs are show-ahead: `event_button` and `event_time` show the head entry combinationally from storage whenever `event_valid` = 1.
- Reset asserted mid-operation:
  - All state clears immediately and asynchronously, and all entries are discarded.
  - Any `press_accepted` pulse in flight is cut.
  - Buttons still requesting are re-granted after reset releases.

## Timing
- Request to acknowledge:
  - `press_activated` sampled high at edge k (eligible, winning) gives `press_accepted` high during cycle k..k+1.
  - The upstream stage drops its request at edge k+1.
- Stored timestamp = counter value sampled at edge k. `event_valid` rises after edge k, so latency is 1 cycle.
- Pop at edge p:
  - Head outputs switch to the next entry after edge p.
  - `event_valid` falls after edge p if that was the last entry.
- A request held continuously after an acknowledge is not re-granted in the cycle where `press_accepted` = 1. The earliest possible regrant is edge k+2.
- Full throughput: one event per cycle when several buttons request together. Example: buttons 0..3 all requesting are granted on consecutive edges in the order 0, 1, 2, 3.

## Test plan
- Reset, then a single request on button 2 at cycle 10:
  - `press_accepted` = 4'b0100 for one cycle.
  - `event_valid` = 1, `event_button` = 2, `event_time` = 10 relative to reset release.
  - `event_count` = 1.
- `press_activated` = 4'b1111 all at once, each dropped one cycle after its acknowledge:
  - Acknowledges 0001, 0010, 0100, 1000 on 4 consecutive cycles.
  - FIFO pops in order 0, 1, 2, 3 with timestamps increasing by 1.
- Depth 8, button 1 pressed 9 times with no reads:
  - `fifo_full` = 1 after 8 events; the ninth request stays unacknowledged.
  - After one pop, the ninth is accepted on the following cycle; `event_count` returns to 8.
- Push and pop on the same edge with count = 3: count stays 3, both pointers advance, head data is correct across pointer wrap 7→0.
- `event_read` pulsed while empty: count stays 0, pointers unchanged, outputs stay 0.
- Reset asserted asynchronously between edges with 5 entries stored and an acknowledge in flight:
  - All outputs 0 immediately.
  - After release, a still-held request is accepted with a timestamp counted from 0.

Source files
------------

// File: rtl/push_button_event_fifo_if.sv
// Bundle of press-request/acknowledge and event-pop signals for push_button_event_fifo.
// No logic inside; latency and timing are defined by the module driving the slave modport.
// Backpressure is carried by fifo_full and by press_accepted staying low while the FIFO is full.
interface push_button_event_fifo_if #(
    parameter int NUM_BUTTONS = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIME_WIDTH  = 16
);
    localparam int IDX_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [NUM_BUTTONS-1:0] press_activated;
    logic [NUM_BUTTONS-1:0] press_accepted;
    logic                   event_valid;
    logic [IDX_W-1:0]       event_button;
    logic [TIME_WIDTH-1:0]  event_time;
    logic                   event_read;
    logic [PTR_W:0]         event_count;
    logic                   fifo_full;

    // Button stages and the event consumer
    modport master (
        output press_activated,
        output event_read,
        input  press_accepted,
        input  event_valid,
        input  event_button,
        input  event_time,
        input  event_count,
        input  fifo_full
    );

    // The arbiter/FIFO itself
    modport slave (
        input  press_activated,
        input  event_read,
        output press_accepted,
        output event_valid,
        output event_button,
        output event_time,
        output event_count,
        output fifo_full
    );
endinterface

// File: rtl/push_button_event_fifo.sv
// Fixed-priority arbiter over button press requests feeding a timestamped event FIFO.
// Latency: acknowledge and stored event visible 1 cycle after the winning request is sampled.
// Backpressure: no grants while full; requests stay pending upstream, a pop frees a slot for the next cycle.
module push_button_event_fifo #(
    parameter int NUM_BUTTONS = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIME_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    push_button_event_fifo_if.slave       evt
);
    localparam int IDX_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [TIME_WIDTH-1:0]  time_cnt;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W:0]         count;
    logic [NUM_BUTTONS-1:0] accepted;

    // Entry storage is never reset; only count decides what is meaningful.
    logic [IDX_W-1:0]       button_mem [FIFO_DEPTH];
    logic [TIME_WIDTH-1:0]  time_mem   [FIFO_DEPTH];

    logic                   full;
    logic                   empty;
    logic [NUM_BUTTONS-1:0] eligible;
    logic [NUM_BUTTONS-1:0] grant_vec;
    logic [IDX_W-1:0]       grant_idx;
    logic                   push;
    logic                   pop;

    // Full is taken from the registered count, so a pop on a full FIFO cannot admit a push on the same edge.
    assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty = (count == '0);

    // A button still showing its acknowledge is masked so a slow-to-clear request is not taken twice.
    assign eligible = evt.press_activated & ~accepted & {NUM_BUTTONS{~full}};

    // Lowest-index eligible request wins; at most one grant per cycle.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (eligible[i] && (grant_vec == '0)) begin
                grant_vec[i] = 1'b1;
                grant_idx    = IDX_W'(i);
            end
        end
    end

    assign push = |grant_vec;
    assign pop  = evt.event_read & ~empty;

    // Free-running timestamp, wraps naturally at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            time_cnt <= '0;
        end else begin
            time_cnt <= time_cnt + 1'b1;
        end
    end

    // Registered one-cycle acknowledge for the winning button.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            accepted <= '0;
        end else begin
            accepted <= grant_vec;
        end
    end

    // Pointer and occupancy bookkeeping; power-of-2 depth lets the pointers wrap by overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Capture {button, timestamp} of the granted press at the write pointer.
    always_ff @(posedge clock) begin
        if (push) begin
            button_mem[wr_ptr] <= grant_idx;
            time_mem[wr_ptr]   <= time_cnt;
        end
    end

    assign evt.press_accepted = accepted;
    assign evt.event_valid    = ~empty;
    assign evt.event_count    = count;
    assign evt.fifo_full      = full;
    // Show-ahead head outputs, forced to zero when nothing is stored.
    assign evt.event_button   = empty ? '0 : button_mem[rd_ptr];
    assign evt.event_time     = empty ? '0 : time_mem[rd_ptr];

endmodule

// File: tb/tb_push_button_event_fifo.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based event model.
// Inputs change and outputs are sampled on the falling clock edge.
// The model keeps a list of stored events, a cycle counter and the last acknowledge vector.
module tb_push_button_event_fifo;
    localparam int NB = 4;
    localparam int D  = 8;
    localparam int TW = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [NB-1:0] req = '0;
    logic          rd  = 1'b0;

    push_button_event_fifo_if #(.NUM_BUTTONS(NB), .FIFO_DEPTH(D), .TIME_WIDTH(TW)) bus ();

    assign bus.press_activated = req;
    assign bus.event_read      = rd;

    push_button_event_fifo #(.NUM_BUTTONS(NB), .FIFO_DEPTH(D), .TIME_WIDTH(TW)) dut (
        .clock (clock),
        .reset (reset),
        .evt   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int btn;
        int ts;
    } ev_t;

    ev_t           q[$];
    logic [NB-1:0] acc_m = '0;
    int            t_m = 0;
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] eb;
        logic [31:0] et;
        eb = 0;
        et = 0;
        if (q.size() > 0) begin
            eb = q[0].btn;
            et = q[0].ts;
        end
        chk({tag, "_acc"},   bus.press_accepted, acc_m);
        chk({tag, "_valid"}, bus.event_valid,    (q.size() > 0) ? 1 : 0);
        chk({tag, "_count"}, bus.event_count,    q.size());
        chk({tag, "_full"},  bus.fifo_full,      (q.size() == D) ? 1 : 0);
        chk({tag, "_btn"},   bus.event_button,   eb);
        chk({tag, "_time"},  bus.event_time,     et);
    endtask

    // One clock: predict from the spec rules, let the edge happen, compare at the falling edge.
    task automatic cycle(input string tag);
        logic [NB-1:0] g;
        int            gi;
        bit            found;
        g = '0;
        gi = 0;
        found = 0;
        if (q.size() < D) begin
            for (int i = 0; i < NB; i++) begin
                if (req[i] && !acc_m[i] && !found) begin
                    found = 1;
                    gi = i;
                    g[i] = 1'b1;
                end
            end
        end
        if (rd && q.size() > 0) void'(q.pop_front());
        if (found) q.push_back('{gi, t_m});
        acc_m = g;
        t_m = (t_m + 1) % (1 << TW);
        @(posedge clock);
        @(negedge clock);
        check_outputs(tag);
    endtask

    // Called at a falling edge: reset pulses between clock edges and releases before the next rising edge.
    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1;
        q.delete();
        acc_m = '0;
        t_m = 0;
        check_outputs("arst");
        #1 reset = 1'b0;
    endtask

    initial begin
        int tstart;
        int n;

        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tstart;
        int n;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check_outputs("reset");
        reset = 1'b0;

        // Single request on button 2 at cycle 10
        repeat (10) cycle("idle");
        req = 4'b0100;
        cycle("b2");
        chk("b2_ack",   bus.press_accepted, 4'b0100);
        chk("b2_btn",   bus.event_button,   2);
        chk("b2_time",  bus.event_time,     10);
        chk("b2_count", bus.event_count,    1);
        req = '0;
        cycle("b2_drop");
        chk("b2_ack_pulse", bus.press_accepted, 0);
        rd = 1'b1;
        cycle("b2_pop");
        rd = 1'b0;

        // All four at once, each dropped after its acknowledge
        req = 4'b1111;
        tstart = t_m;
        for (int i = 0; i < 4; i++) begin
            cycle("all4");
            chk("all4_order", bus.press_accepted, 32'(1 << i));
            req = req & ~acc_m;
        end
        cycle("all4_tail");
        for (int i = 0; i < 4; i++) begin
            chk("all4_pop_btn",  bus.event_button, i);
            chk("all4_pop_time", bus.event_time,   tstart + i);
            rd = 1'b1;
            cycle("all4_pop");
            rd = 1'b0;
        end

        // Button 1 pressed until full, ninth request must wait for a pop
        n = 0;
        while (q.size() < D && n < 40) begin
            req[1] = ~acc_m[1];
            cycle("fill");
            n++;
        end
        chk("fill_full",  bus.fifo_full,   1);
        chk("fill_count", bus.event_count, 8);
        req[1] = 1'b1;
        repeat (3) cycle("full_hold");
        chk("full_noack", bus.press_accepted, 0);
        rd = 1'b1;
        cycle("full_pop");
        rd = 1'b0;
        chk("full_pop_noack", bus.press_accepted, 0);
        chk("full_pop_count", bus.event_count,    7);
        cycle("full_ninth");
        chk("ninth_ack",   bus.press_accepted, 4'b0010);
        chk("ninth_count", bus.event_count,    8);
        req = '0;

        // Drain to 3, then push and pop together across the pointer wrap
        rd = 1'b1;
        while (q.size() > 3) cycle("drain3");
        for (int i = 0; i < 12; i++) begin
            req = ~acc_m;
            cycle("pushpop");
            chk("pushpop_count", bus.event_count, 3);
        end
        req = '0;

        // Pops while empty
        while (q.size() > 0) cycle("drain0");
        repeat (3) cycle("empty_rd");
        chk("empty_count", bus.event_count,  0);
        chk("empty_valid", bus.event_valid,  0);
        chk("empty_btn",   bus.event_button, 0);
        rd = 1'b0;
        req = 4'b1000;
        cycle("after_empty");
        chk("after_empty_btn", bus.event_button, 3);
        req = '0;
        rd = 1'b1;
        cycle("after_empty_pop");
        rd = 1'b0;

        // Asynchronous reset with 5 entries stored and an acknowledge in flight
        for (int i = 0; i < 5; i++) begin
            req = ~acc_m;
            cycle("pre_rst");
        end
        chk("pre_rst_count", bus.event_count, 5);
        req = 4'b0001;
        async_reset_pulse();
        cycle("post_rst");
        chk("post_rst_ack",   bus.press_accepted, 4'b0001);
        chk("post_rst_time",  bus.event_time,     0);
        chk("post_rst_count", bus.event_count,    1);
        req = '0;

        // Random traffic, first slow reader then fast reader
        for (int i = 0; i < 400; i++) begin
            req = NB'($urandom);
            rd  = ($urandom_range(0, 2) == 0);
            cycle("rand_slow");
        end
        for (int i = 0; i < 400; i++) begin
            req = NB'($urandom);
            rd  = ($urandom_range(0, 2) != 0);
            cycle("rand_fast");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
